// File: rtl/sequence_generator.sv
// sequence_generator
//   Serial pattern transmitter. On start it latches a PATTERN_W-bit pattern
//   and sends it MSB first, one bit per clk. The pattern is repeated
//   max(repeat_count,1) times, with `gap` idle cycles between repetitions.
//   After the last bit of the last repetition there is one DONE cycle.
// Ports
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   start             begin a transmission (sampled only while idle)
//   pattern           pattern to send, MSB first
//   repeat_count      number of repetitions (0 behaves as 1)
//   gap               idle cycles between repetitions (0 = back-to-back)
//   abort             drop the transmission at once; done is not raised
//   stream            serial data bit, 0 whenever stream_valid=0
//   stream_valid      stream carries a pattern bit this cycle
//   sof               first (MSB) bit of each repetition
//   busy              high in SEND, GAP and DONE
//   done              one-cycle pulse after the final bit
module sequence_generator #(
  parameter int PATTERN_W = 5,
  parameter int CNT_W     = 8,
  parameter int GAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     repeat_count,
  input  logic [GAP_W-1:0]     gap,
  input  logic                 abort,
  output logic                 stream,
  output logic                 stream_valid,
  output logic                 sof,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(PATTERN_W);
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]     reps_q, reps_d;   // repetitions left, including the one on the wire
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [GAP_W-1:0]     gcnt_q, gcnt_d;   // idle cycles left in the current gap
  logic [IDX_W-1:0]     idx_q, idx_d;     // index of the bit currently on stream
  logic                 stream_d, valid_d, sof_d, busy_d, done_d;
  logic [IDX_W-1:0]     idx_dec;

  assign idx_dec = idx_q - 1'b1;

  // Every output is computed one cycle ahead from the next state, so the
  // registered outputs always describe the state the FSM is currently in.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    reps_d   = reps_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    idx_d    = idx_q;
    stream_d = 1'b0;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort beats start while idle
        if (start && !abort) begin
          state_d  = S_SEND;
          pat_d    = pattern;
          reps_d   = (repeat_count == '0) ? CNT_W'(1) : repeat_count;
          gap_d    = gap;
          idx_d    = MSB_IDX;
          stream_d = pattern[PATTERN_W-1];
          valid_d  = 1'b1;
          sof_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end

      S_SEND: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d    = idx_dec;
          stream_d = pat_q[idx_dec];
          valid_d  = 1'b1;
        end else if (reps_q != CNT_W'(1)) begin
          reps_d = reps_q - 1'b1;
          if (gap_q == '0) begin
            idx_d    = MSB_IDX;
            stream_d = pat_q[PATTERN_W-1];
            valid_d  = 1'b1;
            sof_d    = 1'b1;
          end else begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (gcnt_q == GAP_W'(1)) begin
          state_d  = S_SEND;
          idx_d    = MSB_IDX;
          stream_d = pat_q[PATTERN_W-1];
          valid_d  = 1'b1;
          sof_d    = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      stream_d = 1'b0;
      valid_d  = 1'b0;
      sof_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pat_q        <= '0;
      reps_q       <= '0;
      gap_q        <= '0;
      gcnt_q       <= '0;
      idx_q        <= '0;
      stream       <= 1'b0;
      stream_valid <= 1'b0;
      sof          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      reps_q       <= reps_d;
      gap_q        <= gap_d;
      gcnt_q       <= gcnt_d;
      idx_q        <= idx_d;
      stream       <= stream_d;
      stream_valid <= valid_d;
      sof          <= sof_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator. Per-cycle traces are shifted into
// 32-bit vectors (first cycle after the start edge ends up most significant)
// and compared against hand-written waveforms.
module tb_sequence_generator;
  localparam int PW = 5, CW = 8, GW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [PW-1:0] pattern;
  logic [CW-1:0] repeat_count;
  logic [GW-1:0] gap;
  logic          stream, stream_valid, sof, busy, done;

  int n_chk = 0, n_pass = 0;
  logic [31:0] t_vld, t_str, t_sof, t_busy, t_done;
  int busy_n, sof_n, done_n, hits;
  logic [4:0] win;

  always #5 clk = ~clk;

  sequence_generator #(.PATTERN_W(PW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_count(repeat_count), .gap(gap), .abort(abort),
    .stream(stream), .stream_valid(stream_valid), .sof(sof),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Returns at the negedge of cycle 1 (first cycle after the start edge).
  task automatic go(input logic [PW-1:0] p, input logic [CW-1:0] r, input logic [GW-1:0] g);
    @(negedge clk);
    pattern = p; repeat_count = r; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples n cycles at negedges. After sampling cycle dis_on the inputs are
  // disturbed (start held, new pattern/count/gap) until cycle dis_off; abort
  // is held from cycle ab_on to ab_off. 0 disables.
  task automatic capture(input int n, input int dis_on, input int dis_off,
                         input int ab_on, input int ab_off);
    t_vld = '0; t_str = '0; t_sof = '0; t_busy = '0; t_done = '0;
    busy_n = 0; sof_n = 0; done_n = 0; hits = 0; win = '0;
    for (int i = 1; i <= n; i++) begin
      if (i > 1) @(negedge clk);
      t_vld  = {t_vld[30:0], stream_valid};
      t_str  = {t_str[30:0], stream};
      t_sof  = {t_sof[30:0], sof};
      t_busy = {t_busy[30:0], busy};
      t_done = {t_done[30:0], done};
      busy_n += busy ? 1 : 0;
      sof_n  += sof ? 1 : 0;
      done_n += done ? 1 : 0;
      if (stream_valid) begin
        win = {win[3:0], stream};
        if (win == 5'b10011) hits++;
      end
      if (i == dis_on) begin
        start = 1'b1; pattern = 5'b01100; repeat_count = 8'd9; gap = 4'd0;
      end
      if (i == dis_off) start = 1'b0;
      if (i == ab_on) abort = 1'b1;
      if (i == ab_off) abort = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_count = '0; gap = '0;
    #12;
    chk("reset_outs", 32'({stream, stream_valid, sof, busy, done}), 32'd0);
    @(negedge clk) reset = 1'b1;

    // 1: single frame
    go(5'b10011, 8'd1, 4'd0);
    capture(8, 0, 0, 0, 0);
    chk("t1_vld",  t_vld,  32'b11111000);
    chk("t1_str",  t_str,  32'b10011000);
    chk("t1_sof",  t_sof,  32'b10000000);
    chk("t1_busy", t_busy, 32'b11111100);
    chk("t1_done", t_done, 32'b00000100);

    // 2: three frames, gap 2
    go(5'b10011, 8'd3, 4'd2);
    capture(22, 0, 0, 0, 0);
    chk("t2_vld",  t_vld,  32'b1111100111110011111000);
    chk("t2_str",  t_str,  32'b1001100100110010011000);
    chk("t2_sof",  t_sof,  32'b1000000100000010000000);
    chk("t2_done", t_done, 32'b0000000000000000000100);
    chk("t2_busyn", busy_n, 32'd20);

    // 3: repeat 0 acts as 1; repeat 2 gap 0 back-to-back
    go(5'b10011, 8'd0, 4'd0);
    capture(8, 0, 0, 0, 0);
    chk("t3a_vld",  t_vld,  32'b11111000);
    chk("t3a_done", t_done, 32'b00000100);
    go(5'b11010, 8'd2, 4'd0);
    capture(12, 0, 0, 0, 0);
    chk("t3b_vld",  t_vld,  32'b111111111100);
    chk("t3b_str",  t_str,  32'b110101101000);
    chk("t3b_sof",  t_sof,  32'b100001000000);
    chk("t3b_done", t_done, 32'b000000000010);

    // 4: start re-pulsed and inputs changed mid-operation
    go(5'b10011, 8'd2, 4'd1);
    capture(14, 3, 8, 0, 0);
    chk("t4_vld",  t_vld,  32'b11111011111000);
    chk("t4_str",  t_str,  32'b10011010011000);
    chk("t4_sof",  t_sof,  32'b10000010000000);
    chk("t4_busy", t_busy, 32'b11111111111100);
    chk("t4_done", t_done, 32'b00000000000100);

    // 5: abort on 3rd bit of repetition 2, then a normal transmission
    go(5'b10011, 8'd3, 4'd1);
    capture(12, 0, 0, 9, 10);
    chk("t5_vld",  t_vld,  32'b111110111000);
    chk("t5_str",  t_str,  32'b100110100000);
    chk("t5_busy", t_busy, 32'b111111111000);
    chk("t5_donen", done_n, 32'd0);
    go(5'b10011, 8'd1, 4'd0);
    capture(8, 0, 0, 0, 0);
    chk("t5_re_str",  t_str,  32'b10011000);
    chk("t5_re_done", t_done, 32'b00000100);

    // 6: async reset in GAP, then loopback-style run
    go(5'b10011, 8'd3, 4'd1);
    capture(6, 0, 0, 0, 0);
    chk("t6_in_gap_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1 chk("t6_async_rst", 32'({stream, stream_valid, sof, busy, done}), 32'd0);
    @(negedge clk) reset = 1'b1;
    go(5'b10011, 8'd4, 4'd1);
    capture(26, 0, 0, 0, 0);
    chk("t6_hits",  hits,   32'd4);
    chk("t6_sofn",  sof_n,  32'd4);
    chk("t6_donen", done_n, 32'd1);
    chk("t6_busyn", busy_n, 32'd24);

    // maximum repeat_count and gap: 255*5 + 254*15 + 1 busy cycles
    go(5'b10011, 8'd255, 4'd15);
    capture(5090, 0, 0, 0, 0);
    chk("max_busyn", busy_n, 32'd5086);
    chk("max_sofn",  sof_n,  32'd255);
    chk("max_hits",  hits,   32'd255);
    chk("max_donen", done_n, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
